// File: rtl/apb4_arb_pkg.sv
// rtl/apb4_arb_pkg.sv - shared types and constants for the APB4 round-robin arbiter
//
// Contents:
//   arb_state_e  arbiter transfer state (IDLE -> SETUP -> ACCESS)
//   ARB_MAX_REQ  largest supported requester count
//   PPROT_W      width of the APB4 pprot attribute
package apb4_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } arb_state_e;

    localparam int ARB_MAX_REQ = 8;
    localparam int PPROT_W     = 3;

endpackage

// File: rtl/apb4_rr_picker.sv
// rtl/apb4_rr_picker.sv - combinational round-robin pick of one request
//
// Ports:
//   req    in   NUM_REQ  pending requests
//   ptr    in   IW       highest-priority index this round
//   grant  out  NUM_REQ  one-hot winner, 0 when no request
//   idx    out  IW       index of the winner
//   valid  out  1        at least one request present
module apb4_rr_picker
    import apb4_arb_pkg::*;
#(
    parameter  int NUM_REQ = 2,
    localparam int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IW-1:0]      idx,
    output logic               valid
);

    // Scan from ptr upwards, wrapping, and keep the first hit.
    always_comb begin : pick
        int j;
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        j     = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            j = int'(ptr) + i;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            if (!valid && req[j]) begin
                valid    = 1'b1;
                grant[j] = 1'b1;
                idx      = IW'(j);
            end
        end
    end

endmodule

// File: rtl/apb4_rr_arbiter.sv
// rtl/apb4_rr_arbiter.sv - N-to-1 APB4 round-robin requester arbiter
//
// Optional feature: define APB4_ARB_TIMEOUT_EN to abort an ACCESS phase
// that has waited TIMEOUT_CYC cycles, answering the requester with pslverr.
//
// Ports:
//   clk_i, rst_i                 clock, async active-high reset
//   req_psel_i/penable_i/pwrite_i  per-requester control (NUM_REQ each)
//   req_paddr_i/pprot_i/pstrb_i/pwdata_i  per-requester fields, packed, req0 in LSBs
//   req_pready_o/req_pslverr_o   per-requester response (granted one only)
//   req_prdata_o                 shared read data, valid with req_pready_o
//   psel_o..pwdata_o             slave request
//   prdata_i/pready_i/pslverr_i  slave response
//   grant_o                      one-hot owner, 0 in IDLE
module apb4_rr_arbiter
    import apb4_arb_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [NUM_REQ-1:0]                req_psel_i,
    input  logic [NUM_REQ-1:0]                req_penable_i,
    input  logic [NUM_REQ-1:0]                req_pwrite_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]     req_paddr_i,
    input  logic [NUM_REQ*PPROT_W-1:0]        req_pprot_i,
    input  logic [NUM_REQ*DATA_WIDTH/8-1:0]   req_pstrb_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]     req_pwdata_i,
    output logic [NUM_REQ-1:0]                req_pready_o,
    output logic [DATA_WIDTH-1:0]             req_prdata_o,
    output logic [NUM_REQ-1:0]                req_pslverr_o,
    output logic                              psel_o,
    output logic                              penable_o,
    output logic                              pwrite_o,
    output logic [ADDR_WIDTH-1:0]             paddr_o,
    output logic [PPROT_W-1:0]                pprot_o,
    output logic [DATA_WIDTH/8-1:0]           pstrb_o,
    output logic [DATA_WIDTH-1:0]             pwdata_o,
    input  logic [DATA_WIDTH-1:0]             prdata_i,
    input  logic                              pready_i,
    input  logic                              pslverr_i,
    output logic [NUM_REQ-1:0]                grant_o
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int SW = DATA_WIDTH / 8;

    arb_state_e           state;
    logic [NUM_REQ-1:0]   grant;
    logic [IW-1:0]        gidx;
    logic [IW-1:0]        ptr;
    logic [NUM_REQ-1:0]   pick_grant;
    logic [IW-1:0]        pick_idx;
    logic                 pick_valid;
    logic                 tmo;
    logic                 done;

    apb4_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .req   (req_psel_i),
        .ptr   (ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

`ifdef APB4_ARB_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
    logic [CW-1:0] tmo_cnt;

    // Counts ACCESS cycles spent waiting; cleared whenever ACCESS is left.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tmo_cnt <= '0;
        end else if (state == ST_ACCESS && !pready_i) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end else begin
            tmo_cnt <= '0;
        end
    end

    assign tmo = (state == ST_ACCESS) && !pready_i && (tmo_cnt == CW'(TIMEOUT_CYC - 1));
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYC;
    assign tmo            = 1'b0;
`endif

    assign done    = (state == ST_ACCESS) && (pready_i || tmo);
    assign grant_o = grant;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= ST_IDLE;
            grant <= '0;
            gidx  <= '0;
            ptr   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        grant <= pick_grant;
                        gidx  <= pick_idx;
                        state <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    state <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (done) begin
                        state <= ST_IDLE;
                        grant <= '0;
                        ptr   <= (gidx == IW'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    grant <= '0;
                end
            endcase
        end
    end

    // grant is zero in IDLE, so every forwarded field collapses to 0 there.
    // A requester that dropped psel/penable mid-transfer gets no response.
    always_comb begin
        psel_o        = (state != ST_IDLE);
        penable_o     = (state == ST_ACCESS);
        pwrite_o      = 1'b0;
        paddr_o       = '0;
        pprot_o       = '0;
        pstrb_o       = '0;
        pwdata_o      = '0;
        req_pready_o  = '0;
        req_pslverr_o = '0;
        req_prdata_o  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                pwrite_o = req_pwrite_i[i];
                paddr_o  = req_paddr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
                pprot_o  = req_pprot_i[i*PPROT_W +: PPROT_W];
                pstrb_o  = req_pstrb_i[i*SW +: SW];
                pwdata_o = req_pwdata_i[i*DATA_WIDTH +: DATA_WIDTH];
                req_pready_o[i]  = done && req_psel_i[i] && req_penable_i[i];
                req_pslverr_o[i] = done && req_psel_i[i] && req_penable_i[i] && (pslverr_i || tmo);
            end
        end
        if (state == ST_ACCESS && !tmo) begin
            req_prdata_o = prdata_i;
        end
    end

endmodule

// File: tb/tb_apb4_rr_arbiter.sv
// tb/tb_apb4_rr_arbiter.sv - self-checking bench for apb4_rr_arbiter
module tb_apb4_rr_arbiter;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [N-1:0]    r_psel, r_pen, r_write;
    logic [AW-1:0]   r_addr [N];
    logic [DW-1:0]   r_wdata[N];
    logic [SW-1:0]   r_strb [N];

    logic [N-1:0]    req_pready_o, req_pslverr_o, grant_o;
    logic [DW-1:0]   req_prdata_o;
    logic            psel_o, penable_o, pwrite_o;
    logic [AW-1:0]   paddr_o;
    logic [2:0]      pprot_o;
    logic [SW-1:0]   pstrb_o;
    logic [DW-1:0]   pwdata_o;
    logic [DW-1:0]   prdata_i;
    logic            pready_i, pslverr_i;

    apb4_rr_arbiter #(
        .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYC(16)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .req_psel_i    (r_psel),
        .req_penable_i (r_pen),
        .req_pwrite_i  (r_write),
        .req_paddr_i   ({r_addr[1], r_addr[0]}),
        .req_pprot_i   ({3'b010, 3'b001}),
        .req_pstrb_i   ({r_strb[1], r_strb[0]}),
        .req_pwdata_i  ({r_wdata[1], r_wdata[0]}),
        .req_pready_o  (req_pready_o),
        .req_prdata_o  (req_prdata_o),
        .req_pslverr_o (req_pslverr_o),
        .psel_o        (psel_o),
        .penable_o     (penable_o),
        .pwrite_o      (pwrite_o),
        .paddr_o       (paddr_o),
        .pprot_o       (pprot_o),
        .pstrb_o       (pstrb_o),
        .pwdata_o      (pwdata_o),
        .prdata_i      (prdata_i),
        .pready_i      (pready_i),
        .pslverr_i     (pslverr_i),
        .grant_o       (grant_o)
    );

    // Slave model: ready after slv_wait ACCESS cycles, never for 0xBAD,
    // error for addresses 0xExxx, read data = low half of the address.
    int slv_wait = 0;
    int acc_cnt  = 0;
    assign pready_i  = psel_o && penable_o && (acc_cnt >= slv_wait) && (paddr_o != 32'hBAD);
    assign pslverr_i = pready_i && (paddr_o[15:12] == 4'hE);
    assign prdata_i  = (psel_o && penable_o) ? {16'h0, paddr_o[15:0]} : '0;
    always @(posedge clk) acc_cnt <= (psel_o && penable_o && !pready_i) ? acc_cnt + 1 : 0;

    typedef struct {
        int          r;
        logic [31:0] data;
        logic        chk_data;
        logic        err;
        int          lat;
    } exp_t;

    exp_t sbq[$];
    exp_t last_exp[N];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   pulses = 0;
    int   pops   = 0;
    int   start_cyc[N];
    int   rep[N];
    logic chk_setup = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input int r, input logic w, input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] exp_d, input logic exp_e, input int lat);
        exp_t e;
        r_psel[r]    = 1'b1;
        r_pen[r]     = 1'b0;
        r_write[r]   = w;
        r_addr[r]    = a;
        r_wdata[r]   = wd;
        r_strb[r]    = w ? 4'hF : 4'h0;
        start_cyc[r] = cyc;
        e = '{r: r, data: exp_d, chk_data: !w, err: exp_e, lat: lat};
        last_exp[r] = '{r: r, data: exp_d, chk_data: !w, err: exp_e, lat: -1};
        sbq.push_back(e);
    endtask

    // One clock of requester behaviour: sample at negedge, drive after posedge.
    task automatic step();
        exp_t e;
        logic [N-1:0] nxt_psel, nxt_pen, reiss, oh;
        @(negedge clk);
        cyc++;
        if (req_pready_o != '0) pulses++;
        if (chk_setup && psel_o && !penable_o) begin
            check("setup_addr",  paddr_o,  32'h4);
            check("setup_wdata", pwdata_o, 32'hDEAD_BEEF);
            check("setup_ctl",   {pwrite_o, pstrb_o, pprot_o}, {1'b1, 4'hF, 3'b001});
            chk_setup = 1'b0;
        end
        nxt_psel = r_psel;
        nxt_pen  = r_pen;
        reiss    = '0;
        for (int r = 0; r < N; r++) begin
            if (r_psel[r] && r_pen[r] && req_pready_o[r]) begin
                if (sbq.size() == 0) begin
                    check("sb_empty", sbq.size(), 1);
                end else begin
                    e = sbq.pop_front();
                    pops++;
                    oh = '0;
                    oh[e.r] = 1'b1;
                    check("resp_req",    r, e.r);
                    check("pready_vec",  req_pready_o, oh);
                    check("grant_vec",   grant_o, oh);
                    check("pslverr_vec", req_pslverr_o, e.err ? oh : '0);
                    if (e.chk_data) check("prdata", req_prdata_o, e.data);
                    if (e.lat >= 0) check("latency", cyc - start_cyc[r], e.lat);
                end
                if (rep[r] > 0) begin
                    rep[r]--;
                    nxt_pen[r] = 1'b0;
                    reiss[r]   = 1'b1;
                end else begin
                    nxt_psel[r] = 1'b0;
                    nxt_pen[r]  = 1'b0;
                end
            end else if (r_psel[r]) begin
                nxt_pen[r] = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        r_psel = nxt_psel;
        r_pen  = nxt_pen;
        for (int r = 0; r < N; r++) begin
            if (reiss[r]) begin
                start_cyc[r] = cyc;
                sbq.push_back(last_exp[r]);
            end
        end
    endtask

    task automatic drain(input string tag, input int budget);
        for (int c = 0; c < budget && sbq.size() > 0; c++) step();
        check({tag, "_drain"}, sbq.size(), 0);
        check({tag, "_pulses"}, pulses, pops);
    endtask

    initial begin
        r_psel = '0; r_pen = '0; r_write = '0;
        for (int r = 0; r < N; r++) begin
            r_addr[r] = '0; r_wdata[r] = '0; r_strb[r] = '0; rep[r] = 0; start_cyc[r] = 0;
        end

        // 1: reset state, then idle with no requests
        #12;
        check("rst_ctl",  {psel_o, penable_o, pwrite_o, grant_o, req_pready_o, req_pslverr_o}, '0);
        check("rst_data", {req_prdata_o, paddr_o}, '0);
        @(posedge clk); #1;
        rst = 1'b0;
        step(); step(); step();
        check("idle_stay", {psel_o, grant_o}, '0);

        // 2: single write from req0, immediate slave
        chk_setup = 1'b1;
        issue(0, 1'b1, 32'h4, 32'hDEAD_BEEF, 32'h0, 1'b0, 3);
        drain("single", 20);
        check("setup_seen", chk_setup, 1'b0);

        // 4: four slave wait states, both requesters pending (pointer at req1)
        slv_wait = 4;
        issue(1, 1'b1, 32'h40, 32'h1234_5678, 32'h0, 1'b0, 7);
        issue(0, 1'b0, 32'h50, 32'h0, 32'h50, 1'b0, 14);
        drain("waits", 40);
        slv_wait = 0;

        // 5: slave error, only req1 flagged (moves pointer back to req0)
        issue(1, 1'b1, 32'hE000, 32'hCAFE, 32'h0, 1'b1, 3);
        drain("slverr", 20);

        // 3: contention, req0 back-to-back -> grants 01, 10, 01
        issue(0, 1'b0, 32'h1111, 32'h0, 32'h1111, 1'b0, 3);
        issue(1, 1'b0, 32'h2222, 32'h0, 32'h2222, 1'b0, 6);
        rep[0] = 1;
        drain("contend", 40);

`ifdef APB4_ARB_TIMEOUT_EN
        // 6: slave never ready for req1 -> forced error after 16 ACCESS cycles
        issue(1, 1'b0, 32'hBAD, 32'h0, 32'h0, 1'b1, 18);
        issue(0, 1'b0, 32'h2222, 32'h0, 32'h2222, 1'b0, -1);
        drain("timeout", 60);
`endif

        // async reset mid-transfer drops slave psel at once
        r_psel[0] = 1'b1; r_pen[0] = 1'b0; r_write[0] = 1'b0; r_addr[0] = 32'h10;
        @(posedge clk); #1;
        r_pen[0] = 1'b1;
        @(posedge clk); #1;
        check("mid_psel", psel_o, 1'b1);
        rst = 1'b1;
        #1;
        check("mid_rst", {psel_o, penable_o, grant_o}, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
